// File: rtl/fu_pkg.sv
// Shared types and constants for the functional-unit scheduler.
package fu_pkg;
  localparam int DATA_W      = 8;
  localparam int MUL_LAT_DEF = 2;
  localparam int CNT_W       = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_RESP
  } state_e;
endpackage

// File: rtl/fu_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer moves to the loser on each advance strobe.
module fu_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic advance_i,
  output logic grant_o
);
  logic ptr_q, ptr_d;

  always_comb begin
    if (valid0_i && valid1_i) grant_o = ptr_q;
    else                      grant_o = valid1_i;
  end

  assign ptr_d = advance_i ? ~grant_o : ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fu_units.sv
// Combinational 8-bit functional units shared by the scheduler; results are modulo 2^W.
module adder #(parameter int W = 8) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i + b_i;
endmodule

module subtractor #(parameter int W = 8) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i - b_i;
endmodule

module multiplier #(parameter int W = 8) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i * b_i;
endmodule

module bitwise_and #(parameter int W = 8) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

module bitwise_or #(parameter int W = 8) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

module bitwise_xor #(parameter int W = 8) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule

// File: rtl/fu_scheduler.sv
// Two-requester scheduler for the shared functional units with a registered result slot.
// Define FU_SCHED_ILLEGAL_OP_EN to add the rsp_err port flagging opcodes 6-7.
module fu_scheduler
  import fu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
`ifdef FU_SCHED_ILLEGAL_OP_EN
  output logic              rsp_err,
`endif
  output logic              busy
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              grant, can_accept, fire;
  logic [2:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b, mul_a, mul_b;
  logic [DATA_W-1:0] add_y, sub_y, mul_y, and_y, or_y, xor_y, alu_y;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_RESP && rsp_ready);
  assign req0_ready = can_accept && !grant && rst_n;
  assign req1_ready = can_accept && grant && rst_n;
  assign fire       = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  fu_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .advance_i (fire),
    .grant_o   (grant)
  );

  // A single-cycle multiply takes the live operands; longer ones read the latch.
  assign mul_a = (MUL_LAT == 1) ? sel_a : mul_a_q;
  assign mul_b = (MUL_LAT == 1) ? sel_b : mul_b_q;

  adder       #(.W(DATA_W)) u_add (.a_i(sel_a), .b_i(sel_b), .y_o(add_y));
  subtractor  #(.W(DATA_W)) u_sub (.a_i(sel_a), .b_i(sel_b), .y_o(sub_y));
  multiplier  #(.W(DATA_W)) u_mul (.a_i(mul_a), .b_i(mul_b), .y_o(mul_y));
  bitwise_and #(.W(DATA_W)) u_and (.a_i(sel_a), .b_i(sel_b), .y_o(and_y));
  bitwise_or  #(.W(DATA_W)) u_or  (.a_i(sel_a), .b_i(sel_b), .y_o(or_y));
  bitwise_xor #(.W(DATA_W)) u_xor (.a_i(sel_a), .b_i(sel_b), .y_o(xor_y));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_y = '0;
    case (sel_op)
      OP_ADD:  alu_y = add_y;
      OP_SUB:  alu_y = sub_y;
      OP_MUL:  alu_y = mul_y;
      OP_AND:  alu_y = and_y;
      OP_OR:   alu_y = or_y;
      OP_XOR:  alu_y = xor_y;
      default: alu_y = '0;
    endcase
  end

`ifdef FU_SCHED_ILLEGAL_OP_EN
  logic err_q, err_d;
  assign rsp_err = err_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
`ifdef FU_SCHED_ILLEGAL_OP_EN
    err_d      = err_q;
`endif
    case (state_q)
      S_MUL_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = mul_y;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: ;
    endcase
    // An accept overrides the drain-to-IDLE so back-to-back ops issue every cycle.
    if (fire) begin
      rsp_id_d = grant;
`ifdef FU_SCHED_ILLEGAL_OP_EN
      err_d = (sel_op > OP_XOR);
`endif
      if (sel_op == OP_MUL && MUL_LAT > 1) begin
        mul_a_d = sel_a;
        mul_b_d = sel_b;
        cnt_d   = CNT_W'(MUL_LAT - 2);
        state_d = S_MUL_WAIT;
      end else begin
        rsp_data_d = alu_y;
        state_d    = S_RESP;
      end
    end
  end

  // NOTE: all state, including the datapath registers, is reset so the result slot reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
`ifdef FU_SCHED_ILLEGAL_OP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
`ifdef FU_SCHED_ILLEGAL_OP_EN
      err_q      <= err_d;
`endif
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_fu_scheduler.sv
// Directed bench for fu_scheduler (MUL_LAT=3); inputs driven and outputs sampled on the falling edge.
module tb_fu_scheduler;
  import fu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_data;
`ifdef FU_SCHED_ILLEGAL_OP_EN
  logic       rsp_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fu_scheduler #(.MUL_LAT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
`ifdef FU_SCHED_ILLEGAL_OP_EN
    .rsp_err    (rsp_err),
`endif
    .busy       (busy)
  );

  task automatic drive0(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive0(1'b1, OP_MUL, 8'h03, 8'h03);
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mul_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mul_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL rst_id: got %b want 0", rsp_id); end
    drive0(1'b1, OP_ADD, 8'h01, 8'h02);
    drive1(1'b1, OP_ADD, 8'h05, 8'h05);
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready0: got %b want 1", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL post_rst_ready1: got %b want 0", req1_ready); end
    @(negedge clk);
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h03)
      begin n_bad++; $display("FAIL post_rst_rsp: got v=%b id=%b d=%h want v=1 id=0 d=03", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_single_add();
    do_reset();
    drive0(1'b1, OP_ADD, 8'hF0, 8'h20);
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'h10) begin n_bad++; $display("FAIL add_data: got %h want 10", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL add_id: got %b want 0", rsp_id); end
`ifdef FU_SCHED_ILLEGAL_OP_EN
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL add_err: got %b want 0", rsp_err); end
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL add_drain: got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_contention();
    logic       exp_id;
    logic [7:0] exp_data;
    do_reset();
    rsp_ready = 1'b1;
    drive0(1'b1, OP_SUB, 8'h05, 8'h07);
    drive1(1'b1, OP_XOR, 8'hAA, 8'h0F);
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      begin n_bad++; $display("FAIL cont_first_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_id   = k[0];
      exp_data = exp_id ? 8'hA5 : 8'hFE;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data)
        begin n_bad++; $display("FAIL cont_rsp%0d: got v=%b id=%b d=%h want v=1 id=%b d=%h", k, rsp_valid, rsp_id, rsp_data, exp_id, exp_data); end
    end
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL cont_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_multiply();
    do_reset();
    rsp_ready = 1'b1;
    drive1(1'b1, OP_MUL, 8'h13, 8'h0B);
    #1;
    n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL mul_accept: got %b want 1", req1_ready); end
    @(negedge clk);
    drive0(1'b1, OP_ADD, 8'h01, 8'h01);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
        begin n_bad++; $display("FAIL mul_wait%0d: got v=%b r0=%b r1=%b busy=%b want 0 0 0 1", k, rsp_valid, req0_ready, req1_ready, busy); end
      @(negedge clk);
    end
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'hD1)
      begin n_bad++; $display("FAIL mul_rsp: got v=%b id=%b d=%h want v=1 id=1 d=d1", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mul_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    rsp_ready = 1'b0;
    drive0(1'b1, OP_AND, 8'h3C, 8'h0F);
    @(negedge clk);
    drive0(1'b1, OP_OR, 8'h01, 8'h80);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h0C || req0_ready !== 1'b0)
        begin n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h r0=%b want v=1 d=0c r0=0", k, rsp_valid, rsp_data, req0_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h81 || rsp_id !== 1'b0)
      begin n_bad++; $display("FAIL bp_next: got v=%b d=%h id=%b want v=1 d=81 id=0", rsp_valid, rsp_data, rsp_id); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_illegal_op();
    do_reset();
    rsp_ready = 1'b0;
    drive0(1'b1, 3'd6, 8'h55, 8'hAA);
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_id !== 1'b0)
      begin n_bad++; $display("FAIL ill_rsp: got v=%b d=%h id=%b want v=1 d=00 id=0", rsp_valid, rsp_data, rsp_id); end
`ifdef FU_SCHED_ILLEGAL_OP_EN
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", rsp_err); end
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ill_drain: got %b want 0", rsp_valid); end
  endtask

  initial begin
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_contention();
    test_multiply();
    test_back_pressure();
    test_illegal_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fu_scheduler.md
# fu_scheduler

Shared-execution scheduler for the 8-bit functional units (adder, subtractor, multiplier, AND/OR/XOR). Two requesters submit operations over valid/ready. A round-robin arbiter grants one operation at a time, and the block sequences it through the selected unit, including a multi-cycle multiplier wait. A single registered result slot returns the result to the requester with valid/ready back-pressure. It sits between the requesting control logic and the combinational unit modules.

## Interface
- `MUL_LAT`, default 2: cycles from multiply accept to `rsp_valid`; legal range 1..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid` / `req1_valid`  in  1  request present; must not depend on ready.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when ANDed with valid.
- `req0_op` / `req1_op`  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6–7 illegal.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8  operands.
- `rsp_valid`  out  1  result slot full.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_id`  out  1  requester that issued the result.
- `rsp_data`  out  8  result, low 8 bits; all arithmetic is modulo 256.
- `rsp_err`  out  1  illegal opcode flag; present only under `FU_SCHED_ILLEGAL_OP_EN`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **States.** IDLE, MUL_WAIT, RESP.
- **Accept condition.** `can_accept = (state==IDLE) || (state==RESP && rsp_ready)`.
  - `reqN_ready = can_accept && grant==N && rst_n`.
  - `rsp_ready` propagates combinationally to `reqN_ready`.
- **Arbitration (2-way round-robin).**
  - Priority pointer `ptr` resets to 0.
  - Only one valid requester: it wins.
  - Both valid: `ptr` wins.
  - After each accepted request, `ptr` moves to the non-granted requester.
  - If no request is accepted, `ptr` holds.
- **Non-MUL accept.** Unit output from the incoming operands is registered into `rsp_data`, `rsp_id` is loaded, and state goes to RESP.
- **MUL accept with MUL_LAT=1.** Same as non-MUL.
- **MUL accept with MUL_LAT>1.**
  - Latch operands, id and op.
  - Load `cnt = MUL_LAT-2` and go to MUL_WAIT.
  - In MUL_WAIT, `cnt` decrements. At `cnt==0`, load the product from the latched operands and go to RESP.
  - No request is accepted during MUL_WAIT.
- **RESP.** `rsp_valid=1`; `rsp_data`, `rsp_id` and `rsp_err` are stable until the handshake.
  - Handshake with no new accept: go to IDLE.
  - Handshake with a same-cycle accept: next state follows the accept rule above, so back-to-back operations run at one per cycle.
- **Reset (any time, including mid-MUL).** State IDLE, `ptr=0`, `cnt=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0x00`, `rsp_err=0`, `busy=0`. The in-flight operation is dropped.

## Timing
- Non-MUL latency: accept at edge N gives `rsp_valid` after edge N.
- MUL latency: `rsp_valid` rises after edge N+MUL_LAT-1.
- Maximum throughput: 1 op/cycle for non-MUL operations with `rsp_ready` held high.
- MUL throughput: 1 op per MUL_LAT cycles.
- Combinational paths:
  - `reqN_valid` → `reqN_ready`.
  - `rsp_ready` → `reqN_ready`.
  - No combinational path from any request input to `rsp_*`.

## Configuration
- **`FU_SCHED_ILLEGAL_OP_EN` defined.**
  - The `rsp_err` port exists.
  - Opcodes 6–7 are accepted with 1-cycle latency and give `rsp_data=0x00`, `rsp_err=1`.
  - Legal opcodes give `rsp_err=0`.
- **Macro undefined.**
  - No `rsp_err` port.
  - Opcodes 6–7 are accepted with 1-cycle latency and give `rsp_data=0x00`, with no flag.

## Structure
- **Package `fu_pkg`.**
  - Opcode enum: `OP_ADD`..`OP_XOR`.
  - State enum: `S_IDLE`, `S_MUL_WAIT`, `S_RESP`.
  - Operand/result width constant (8).
  - Default MUL_LAT.
- **Sub-module `fu_rr_arbiter`.** Two valid inputs, grant output, pointer register, and an advance strobe.
- The existing `adder`, `subtractor`, `multiplier` and `bitwise_*` units are instantiated directly. The multiplier is fed from the operand latch.

## Test plan
- **Reset.** Assert `rst_n` low mid-MUL with `req0_valid=1` → `rsp_valid=0`, `req0_ready=0`, `busy=0`. After release, the next accept goes to req0.
- **Single ADD.** req0 ADD a=0xF0, b=0x20 → next cycle `rsp_valid=1`, `rsp_data=0x10`, `rsp_id=0`.
- **Contention.** Both valid from reset: req0 SUB 0x05−0x07, req1 XOR 0xAA^0x0F, `rsp_ready=1` → req0 result 0xFE, then req1 result 0xA5 on consecutive cycles. With both held valid continuously, ids alternate 0,1,0,1.
- **Multiply latency.** MUL_LAT=3, req1 MUL 0x13×0x0B → `rsp_data=0xD1`, `rsp_id=1`, `rsp_valid` rising exactly 3 cycles after accept. Both readies are 0 during MUL_WAIT.
- **Back-pressure.** `rsp_ready=0` for 4 cycles with req0 AND 0x3C&0x0F pending → `rsp_data=0x0C` stable and `req0_ready=0`. Raising `rsp_ready` with req0 OR 0x01|0x80 valid → same-cycle handshake and accept, then `rsp_data=0x81` on the next cycle.
- **Illegal opcode.** req0 op=6 → `rsp_data=0x00`. With `FU_SCHED_ILLEGAL_OP_EN` defined, `rsp_err=1`. Built without the macro, the same `rsp_data` appears and no `rsp_err` port exists.
